adc_sum_sq_ctrl: RTL and testbench
==================================

Name: adc_sum_sq_ctrl

Overview:
- Sequences the ADC sum-of-squares datapath: arms on software command, aligns to a sync pulse and accumulates adc_data^2 over a programmable 2^N-sample window.
- Publishes a saturated 32-bit result and a result counter; sum_out feeds the software-readable sum-of-squares register (user_data_in).
- Runs single-shot or back-to-back continuous windows.
- Sits on user_clk between the ADC capture and the register bridge.

Parameters:
ADC_WIDTH, 8, signed sample width (two's complement)
ACC_WIDTH, 48, internal accumulator width; must be >= 2*ADC_WIDTH + MAX_LEN_LOG2
MAX_LEN_LOG2, 20, maximum window exponent; larger requests clamp to this

Ports:
user_clk  in  1  single clock for the block
user_rst  in  1  synchronous, active-high reset
ctrl_arm  in  1  start pulse; honoured in IDLE only
ctrl_abort  in  1  pulse; return to IDLE without publishing
ctrl_continuous  in  1  1 = start the next window immediately after publishing
ctrl_len_log2  in  5  window length = 2^ctrl_len_log2 valid samples
sync_in  in  1  alignment pulse that starts the first window
adc_valid  in  1  adc_data qualifier
adc_data  in  ADC_WIDTH  signed sample
sum_out  out  32  last published result
sum_valid  out  1  one-cycle publish strobe
sum_count  out  16  number of published results; wraps
busy  out  1  high in WAIT_SYNC or ACCUM
saturated  out  1  sticky; set when any published result clipped

Behaviour:
- Reset: state=IDLE; sum_out=0, sum_valid=0, sum_count=0, busy=0, saturated=0; accumulator=0, sample counter=0.
- States: IDLE, WAIT_SYNC, ACCUM. busy is registered and equals (state != IDLE).
- IDLE:
  - ctrl_arm=1 -> WAIT_SYNC next cycle.
  - Clear saturated on arm.
- WAIT_SYNC:
  - sync_in=1 -> ACCUM next cycle.
  - Clear the accumulator and sample counter.
  - Latch L = min(ctrl_len_log2, MAX_LEN_LOG2).
  - Samples arriving in the sync cycle are not counted.
- ACCUM:
  - Each cycle with adc_valid=1: acc += adc_data*adc_data, as an unsigned square of 2*ADC_WIDTH bits (-128^2 = 16384 for the default width); cnt += 1.
  - adc_valid=0 cycles are ignored. sync_in is ignored.
- Window end: the valid cycle where cnt == 2^L - 1.
  - Register sum_out <= sat32(acc + sq); sat32 yields 0xFFFFFFFF when the value exceeds 2^32-1 and also sets saturated.
  - sum_valid=1 on the following cycle only; sum_count increments on that same cycle.
  - The accumulator reloads 0 and cnt reloads 0 in the same edge.
  - ctrl_continuous sampled at this cycle: 1 -> remain in ACCUM, re-latch L, and count the very next valid sample (no dropped samples, no sync wait); 0 -> IDLE.
- L=0: every valid sample is a complete window; sum_out = its square.
- sum_out holds between publishes.
- ctrl_abort in any state -> IDLE next cycle, with no publish and no sum_count change; abort wins over arm and over window end in the same cycle.
- ctrl_arm while busy: ignored.
- ctrl_len_log2 changes mid-window: no effect until the next window start.
- Dropping ctrl_continuous mid-window: the current window completes and publishes, then IDLE.
- user_rst mid-window: immediate return to reset values; no publish.
- sum_count wraps 0xFFFF -> 0x0000.

Test Plan:
- Reset, then arm, sync, L=2, samples 1,-2,3,-4 all valid -> one cycle after 4th sample: sum_valid=1, sum_out=30, sum_count=1; then busy=0 and state IDLE.
- L=3, continuous=1, constant sample -128 with adc_valid toggling 1/0 -> sum_valid every 16 cycles; each sum_out=131072; no sample lost across window boundaries.
- L=20, continuous=0, constant -128 -> true sum 2^34 -> sum_out=0xFFFFFFFF, saturated=1; next arm clears saturated.
- Abort at sample 3 of an L=4 window -> no sum_valid, sum_count unchanged, busy=0 next cycle; arm+abort in the same cycle from IDLE -> stays IDLE.
- L=0, continuous=1, samples 5,-7 -> two strobes with sum_out 25 then 49; ctrl_len_log2=31 -> clamped to a 2^20 window.
- Arm without sync -> stays WAIT_SYNC, busy=1, no accumulation; user_rst mid-ACCUM -> all outputs return to 0.

Source files
------------

// File: rtl/adc_sum_sq_ctrl.sv
// Sum-of-squares window controller: arms on command, aligns to sync_in, accumulates
// adc_data^2 over 2^L valid samples and publishes a saturated 32-bit result.
module adc_sum_sq_ctrl #(
    parameter int ADC_WIDTH    = 8,
    parameter int ACC_WIDTH    = 48,
    parameter int MAX_LEN_LOG2 = 20
) (
    input  logic                        user_clk,
    input  logic                        user_rst,
    input  logic                        ctrl_arm,
    input  logic                        ctrl_abort,
    input  logic                        ctrl_continuous,
    input  logic [4:0]                  ctrl_len_log2,
    input  logic                        sync_in,
    input  logic                        adc_valid,
    input  logic signed [ADC_WIDTH-1:0] adc_data,
    output logic [31:0]                 sum_out,
    output logic                        sum_valid,
    output logic [15:0]                 sum_count,
    output logic                        busy,
    output logic                        saturated,
    output logic [1:0]                  dbg_state
);

    localparam int CW = MAX_LEN_LOG2 + 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_SYNC = 2'd1,
        ACCUM     = 2'd2
    } state_t;

    state_t                  state;
    logic [ACC_WIDTH-1:0]    acc;
    logic [MAX_LEN_LOG2-1:0] cnt;
    logic [4:0]              len;

    logic signed [2*ADC_WIDTH-1:0] prod;
    logic [ACC_WIDTH-1:0]          acc_sum;
    logic [4:0]                    len_clamp;
    logic [CW-1:0]                 win_len;
    logic                          win_end;
    logic                          over;
    logic [31:0]                   sat_val;

    // The square of a two's-complement sample is non-negative, so the 2W-bit
    // product is reinterpreted as unsigned before widening.
    assign prod      = adc_data * adc_data;
    assign acc_sum   = acc + ACC_WIDTH'($unsigned(prod));
    assign len_clamp = (ctrl_len_log2 > 5'(MAX_LEN_LOG2)) ? 5'(MAX_LEN_LOG2) : ctrl_len_log2;
    assign win_len   = CW'(1) << len;
    assign win_end   = adc_valid && ({1'b0, cnt} == (win_len - CW'(1)));
    assign over      = acc_sum > ACC_WIDTH'(32'hFFFF_FFFF);
    assign sat_val   = over ? 32'hFFFF_FFFF : acc_sum[31:0];
    assign dbg_state = state;

    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            len       <= '0;
            sum_out   <= '0;
            sum_valid <= 1'b0;
            sum_count <= '0;
            busy      <= 1'b0;
            saturated <= 1'b0;
        end else begin
            sum_valid <= 1'b0;
            if (ctrl_abort) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (ctrl_arm) begin
                            state     <= WAIT_SYNC;
                            busy      <= 1'b1;
                            saturated <= 1'b0;
                        end
                    end
                    WAIT_SYNC: begin
                        acc <= '0;
                        cnt <= '0;
                        if (sync_in) begin
                            len   <= len_clamp;
                            state <= ACCUM;
                        end
                    end
                    ACCUM: begin
                        if (win_end) begin
                            sum_out   <= sat_val;
                            sum_valid <= 1'b1;
                            sum_count <= sum_count + 16'd1;
                            if (over) saturated <= 1'b1;
                            acc <= '0;
                            cnt <= '0;
                            // Continuous mode rolls straight into the next window.
                            if (ctrl_continuous) begin
                                len <= len_clamp;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else if (adc_valid) begin
                            acc <= acc_sum;
                            cnt <= cnt + MAX_LEN_LOG2'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adc_sum_sq_ctrl.sv
// Randomized bench for adc_sum_sq_ctrl: per-window sums of squares are computed
// up front from the generated samples and matched against each publish strobe.
module tb_adc_sum_sq_ctrl;

    localparam int AW   = 16;
    localparam int ACW  = 48;
    localparam int MAXL = 6;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ACC  = 2'd2;

    logic          user_clk = 1'b0;
    logic          user_rst;
    logic          ctrl_arm;
    logic          ctrl_abort;
    logic          ctrl_continuous;
    logic [4:0]    ctrl_len_log2;
    logic          sync_in;
    logic          adc_valid;
    logic [AW-1:0] adc_data;
    logic [31:0]   sum_out;
    logic          sum_valid;
    logic [15:0]   sum_count;
    logic          busy;
    logic          saturated;
    logic [1:0]    dbg_state;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    int          strobe_q[$];
    logic [15:0] exp_count = '0;
    bit          exp_sat   = 1'b0;
    int          cyc       = 0;
    longint      lim       = 64'h0000_0000_FFFF_FFFF;

    always #5 user_clk = ~user_clk;

    adc_sum_sq_ctrl #(.ADC_WIDTH(AW), .ACC_WIDTH(ACW), .MAX_LEN_LOG2(MAXL)) dut (
        .user_clk(user_clk), .user_rst(user_rst), .ctrl_arm(ctrl_arm),
        .ctrl_abort(ctrl_abort), .ctrl_continuous(ctrl_continuous),
        .ctrl_len_log2(ctrl_len_log2), .sync_in(sync_in), .adc_valid(adc_valid),
        .adc_data(adc_data), .sum_out(sum_out), .sum_valid(sum_valid),
        .sum_count(sum_count), .busy(busy), .saturated(saturated),
        .dbg_state(dbg_state)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sat32(input longint s);
        logic [63:0] v;
        v = s;
        return (s > lim) ? 32'hFFFF_FFFF : v[31:0];
    endfunction

    function automatic logic [AW-1:0] rnd();
        return AW'($urandom_range(0, 65535));
    endfunction

    // Scoreboard: every strobe must match the oldest expected window sum.
    always @(negedge user_clk) begin
        cyc++;
        if (!user_rst && sum_valid) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_strobe", 1, 0);
            end else begin
                check_eq("sum_out", sum_out, exp_q.pop_front());
            end
            exp_count++;
            check_eq("sum_count", sum_count, exp_count);
            strobe_q.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge user_clk);
        #1;
        ctrl_arm   = 1'b0;
        ctrl_abort = 1'b0;
        sync_in    = 1'b0;
    endtask

    task automatic arm_only(input int len_req, input bit cont);
        ctrl_len_log2   = 5'(len_req);
        ctrl_continuous = cont;
        ctrl_arm        = 1'b1;
        adc_valid       = 1'($urandom_range(0, 1));
        adc_data        = rnd();
        tick();
        exp_sat = 1'b0;
        check_eq("arm_busy", busy, 1);
        check_eq("arm_state", dbg_state, S_WAIT);
        check_eq("arm_clears_sat", saturated, 0);
    endtask

    task automatic sync_pulse();
        sync_in   = 1'b1;
        adc_valid = 1'b1;
        adc_data  = rnd();
        tick();
        adc_valid = 1'b0;
        check_eq("sync_state", dbg_state, S_ACC);
    endtask

    task automatic start(input int len_req, input bit cont);
        arm_only(len_req, cont);
        sync_pulse();
    endtask

    task automatic drive_valid(input logic [AW-1:0] d);
        adc_valid = 1'b1;
        adc_data  = d;
        tick();
        adc_valid = 1'b0;
    endtask

    task automatic feed(input int len_req, input int nwin, input bit alt, input int gap_max,
                        input bit use_fixed, input logic [AW-1:0] fixed_val, input bit drop_last);
        int l;
        int n;
        l = (len_req > MAXL) ? MAXL : len_req;
        n = 1 << l;
        for (int w = 0; w < nwin; w++) begin
            logic [AW-1:0] smp[$];
            longint        sum;
            int            gap;
            smp.delete();
            sum = 0;
            for (int i = 0; i < n; i++) begin
                smp.push_back(use_fixed ? fixed_val : rnd());
                sum += longint'($signed(smp[i])) * longint'($signed(smp[i]));
            end
            exp_q.push_back(sat32(sum));
            if (sum > lim) exp_sat = 1'b1;
            if (drop_last && w == nwin - 1) ctrl_continuous = 1'b0;
            for (int i = 0; i < n; i++) begin
                ctrl_len_log2 = (i == n - 1) ? 5'(len_req) : 5'($urandom_range(0, 31));
                drive_valid(smp[i]);
                gap = alt ? 1 : $urandom_range(0, gap_max);
                for (int g = 0; g < gap; g++) begin
                    adc_data = rnd();
                    sync_in  = ($urandom_range(0, 3) == 0);
                    tick();
                end
            end
        end
    endtask

    task automatic finish_stream();
        int k;
        k = 0;
        while (busy && k < 40) begin
            tick();
            k++;
        end
        check_eq("idle_timeout", busy, 0);
        repeat (2) tick();
        check_eq("drained", exp_q.size(), 0);
        check_eq("saturated", saturated, exp_sat);
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] t1v[4];
        int            len_r;
        bit            cont_r;
        t1v = '{16'd1, 16'hFFFE, 16'd3, 16'hFFFC};

        user_rst = 1'b1; ctrl_arm = 1'b0; ctrl_abort = 1'b0; ctrl_continuous = 1'b0;
        ctrl_len_log2 = '0; sync_in = 1'b0; adc_valid = 1'b0; adc_data = '0;
        repeat (3) tick();
        user_rst = 1'b0;
        tick();
        check_eq("rst_sum_out", sum_out, 0);
        check_eq("rst_sum_valid", sum_valid, 0);
        check_eq("rst_sum_count", sum_count, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_saturated", saturated, 0);
        check_eq("rst_state", dbg_state, S_IDLE);

        // 1, -2, 3, -4 over a 4-sample window
        start(2, 0);
        exp_q.push_back(32'd30);
        for (int i = 0; i < 4; i++) drive_valid(t1v[i]);
        check_eq("t1_valid", sum_valid, 1);
        check_eq("t1_sum", sum_out, 30);
        check_eq("t1_count", sum_count, 1);
        check_eq("t1_busy", busy, 0);
        check_eq("t1_state", dbg_state, S_IDLE);
        tick();
        check_eq("t1_strobe_len", sum_valid, 0);
        check_eq("t1_hold", sum_out, 30);
        finish_stream();

        // continuous L=3, -128 with adc_valid alternating
        strobe_q.delete();
        start(3, 1);
        feed(3, 3, 1, 0, 1, 16'hFF80, 1);
        finish_stream();
        check_eq("t2_strobes", strobe_q.size(), 3);
        if (strobe_q.size() == 3) begin
            check_eq("t2_gap1", strobe_q[1] - strobe_q[0], 16);
            check_eq("t2_gap2", strobe_q[2] - strobe_q[1], 16);
        end

        // saturation: 8 x (-32768)^2 = 2^33
        start(3, 0);
        feed(3, 1, 0, 2, 1, 16'h8000, 0);
        finish_stream();
        check_eq("t3_sat_value", sum_out, 32'hFFFF_FFFF);

        // abort mid-window, abort on the window-end cycle, arm+abort in IDLE
        start(4, 0);
        for (int i = 0; i < 3; i++) drive_valid(rnd());
        ctrl_abort = 1'b1;
        drive_valid(rnd());
        check_eq("t4_busy", busy, 0);
        check_eq("t4_state", dbg_state, S_IDLE);
        check_eq("t4_count", sum_count, exp_count);
        start(1, 0);
        drive_valid(rnd());
        ctrl_abort = 1'b1;
        drive_valid(rnd());
        check_eq("t4_end_abort_valid", sum_valid, 0);
        check_eq("t4_end_abort_count", sum_count, exp_count);
        ctrl_arm   = 1'b1;
        ctrl_abort = 1'b1;
        tick();
        check_eq("t4_arm_abort_busy", busy, 0);
        check_eq("t4_arm_abort_state", dbg_state, S_IDLE);
        finish_stream();

        // L=0 continuous: 5 then -7
        start(0, 1);
        exp_q.push_back(32'd25);
        exp_q.push_back(32'd49);
        drive_valid(16'd5);
        ctrl_continuous = 1'b0;
        drive_valid(16'hFFF9);
        finish_stream();

        // oversized request clamps to 2^MAXL samples
        start(31, 0);
        feed(31, 1, 0, 1, 0, '0, 0);
        finish_stream();

        // armed without sync: samples must not accumulate
        arm_only(1, 0);
        for (int i = 0; i < 8; i++) drive_valid(16'h7FFF);
        check_eq("t7_busy", busy, 1);
        check_eq("t7_state", dbg_state, S_WAIT);
        sync_pulse();
        feed(1, 1, 0, 1, 0, '0, 0);
        finish_stream();

        // random streams
        for (int r = 0; r < 6; r++) begin
            len_r  = $urandom_range(0, 5);
            cont_r = 1'($urandom_range(0, 1));
            start(len_r, cont_r);
            feed(len_r, cont_r ? $urandom_range(2, 4) : 1, 0, 2, 0, '0, cont_r);
            finish_stream();
        end

        // reset in the middle of a window
        start(3, 0);
        for (int i = 0; i < 3; i++) drive_valid(rnd());
        user_rst = 1'b1;
        tick();
        check_eq("t9_sum_out", sum_out, 0);
        check_eq("t9_sum_valid", sum_valid, 0);
        check_eq("t9_sum_count", sum_count, 0);
        check_eq("t9_busy", busy, 0);
        check_eq("t9_saturated", saturated, 0);
        check_eq("t9_state", dbg_state, S_IDLE);
        user_rst  = 1'b0;
        exp_count = '0;
        repeat (3) drive_valid(rnd());
        check_eq("t9_no_publish", sum_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
